// File: rtl/result_reader.sv
// rtl/result_reader.sv - reads 16-bit results stored as byte pairs from one memory lane and streams them out
module result_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH-1:0]   word_count,
    output logic [ADDR_WIDTH-1:0]   r_addr,
    output logic                    mem_we,
    input  logic [DATA_WIDTH-1:0]   r_data,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LO   = 3'd1,
        RD_HI   = 3'd2,
        RD_WAIT = 3'd3,
        OUT     = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            r_addr_q    <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            r_addr_q    <= r_addr_d;
            data_q      <= data_d;
        end
    end

    // r_addr is registered and loaded on entry to each read state, so it is
    // already valid during RD_LO/RD_HI and simply holds everywhere else.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        r_addr_d    = r_addr_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        r_addr_d    = base_addr;
                        state_d     = RD_LO;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD_LO: begin
                r_addr_d = addr_q + ADDR_WIDTH'(1);
                state_d  = RD_HI;
            end
            RD_HI: begin
                data_d[DATA_WIDTH-1:0] = r_data;
                state_d                = RD_WAIT;
            end
            RD_WAIT: begin
                data_d[2*DATA_WIDTH-1:DATA_WIDTH] = r_data;
                state_d                           = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    addr_d      = addr_q + ADDR_WIDTH'(2);
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        state_d = FIN;
                    end else begin
                        r_addr_d = addr_q + ADDR_WIDTH'(2);
                        state_d  = RD_LO;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign r_addr    = r_addr_q;
    assign mem_we    = 1'b0;
    assign out_data  = data_q;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - randomized and directed checks of result_reader against a queue-based model
module tb_result_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  word_count;
    logic [7:0]  r_addr;
    logic        mem_we;
    logic [7:0]  r_data = 8'd0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    result_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .r_addr(r_addr), .mem_we(mem_we),
        .r_data(r_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    logic [7:0]  exp_a [$];
    logic [15:0] got_w [$];
    int          hs_cyc [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc, done_cyc, busy_cnt, stall_obs, done_cnt, stall_left, ready_mode;
    bit done_armed = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        r_data <= mem[r_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every negedge, compare outputs with the expected word queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", {8'd0, r_addr, out_data, out_valid, busy, done, mem_we}, 32'd0);
            exp_q.delete();
            exp_a.delete();
            done_armed = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                chk("mem_we_low", {31'd0, mem_we}, 32'd0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("word", {16'd0, out_data}, {16'd0, exp_q[0]});
                    chk("raddr_in_out", {24'd0, r_addr}, {24'd0, 8'(exp_a[0] + 8'd1)});
                    if (out_ready) begin
                        got_w.push_back(out_data);
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        void'(exp_a.pop_front());
                    end else begin
                        stall_obs++;
                    end
                end
            end
            if (done) begin
                chk("done_expected", {31'd0, done_armed && exp_q.size() == 0}, 32'd1);
                done_armed = 0;
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && got_w.size() == 1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
        end
    end

    task automatic clear_obs();
        got_w.delete();
        hs_cyc.delete();
        busy_cnt  = 0;
        stall_obs = 0;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] a, a1;
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        start_cyc  = cyc;
        for (int i = 0; i < int'(n); i++) begin
            a  = 8'(b + 8'(2 * i));
            a1 = a + 8'd1;
            exp_q.push_back({mem[a1], mem[a]});
            exp_a.push_back(a);
        end
        done_armed = 1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 8'($urandom);
        word_count = 8'($urandom);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic normal_dump();
        clear_obs();
        do_start(8'd10, 8'd3);
        wait_done();
        chk("n_words", got_w.size(), 32'd3);
        if (got_w.size() == 3) begin
            chk("n_w0", {16'd0, got_w[0]}, 32'h0201);
            chk("n_w1", {16'd0, got_w[1]}, 32'h0403);
            chk("n_w2", {16'd0, got_w[2]}, 32'h0605);
            chk("n_first_lat", hs_cyc[0] - start_cyc, 32'd4);
            chk("n_gap1", hs_cyc[1] - hs_cyc[0], 32'd4);
            chk("n_gap2", hs_cyc[2] - hs_cyc[1], 32'd4);
            chk("n_done_lat", done_cyc - hs_cyc[2], 32'd1);
        end
        chk("n_busy_cycles", busy_cnt, 32'd13);
    endtask

    initial begin
        logic [7:0] prev_raddr;
        int d0, t;
        reset = 1'b1;
        start = 1'b0;
        base_addr = 8'd0;
        word_count = 8'd0;
        ready_mode = 0;
        done_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) mem[10 + i] = 8'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {8'd0, r_addr, out_data, out_valid, busy, done, mem_we}, 32'd0);
        reset = 1'b0;

        normal_dump();

        clear_obs();
        ready_mode = 2;
        stall_left = 5;
        do_start(8'd10, 8'd3);
        wait_done();
        ready_mode = 0;
        chk("bp_stall_cycles", stall_obs, 32'd5);
        chk("bp_words", got_w.size(), 32'd3);
        if (got_w.size() == 3) begin
            chk("bp_w0", {16'd0, got_w[0]}, 32'h0201);
            chk("bp_w1", {16'd0, got_w[1]}, 32'h0403);
            chk("bp_w2", {16'd0, got_w[2]}, 32'h0605);
        end

        clear_obs();
        prev_raddr = r_addr;
        do_start(8'd50, 8'd0);
        wait_done();
        chk("zero_done_lat", done_cyc - start_cyc, 32'd1);
        chk("zero_no_words", got_w.size(), 32'd0);
        chk("zero_raddr", {24'd0, r_addr}, {24'd0, prev_raddr});

        clear_obs();
        mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        do_start(8'd254, 8'd2);
        wait_done();
        chk("wrap_words", got_w.size(), 32'd2);
        if (got_w.size() == 2) begin
            chk("wrap_w0", {16'd0, got_w[0]}, 32'h2211);
            chk("wrap_w1", {16'd0, got_w[1]}, 32'h4433);
        end

        clear_obs();
        d0 = done_cnt;
        do_start(8'd10, 8'd3);
        while (cyc != start_cyc + 6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {8'd0, r_addr, out_data, out_valid, busy, done, mem_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 32'd0);
        chk("rst_one_word", got_w.size(), 32'd1);
        normal_dump();

        clear_obs();
        d0 = done_cnt;
        do_start(8'd10, 8'd3);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("busy_in_out", {31'd0, out_valid}, 32'd1);
        start = 1'b1;
        base_addr = 8'd20;
        word_count = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("sb_words", got_w.size(), 32'd3);
        if (got_w.size() == 3) chk("sb_w2", {16'd0, got_w[2]}, 32'h0605);
        chk("sb_one_done", done_cnt - d0, 32'd1);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] b, n;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            b = 8'($urandom);
            n = 8'($urandom_range(0, 6));
            ready_mode = int'($urandom_range(0, 1));
            clear_obs();
            do_start(b, n);
            wait_done();
            chk("rand_count", got_w.size(), {24'd0, n});
        end
        ready_mode = 0;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
